// File: rtl/packet_router_n.sv
// packet_router_n: buffers length-prefixed packets in a circular FIFO and forwards each to one of NPORTS outputs.
// Ports: clk/reset (async, active-low); i_valid/i_data/i_end input beats, i_ready = room for a max-length packet;
// per port p: o_req/o_grant handshake, o_length payload length, o_start/o_end/o_data[8p+7:8p] payload stream;
// drop_cnt saturating discarded-packet count; overflow sticky flag for beats offered while i_ready was low.
// Macro PKT_DROP_BAD_PORT_EN: when defined, headers addressing a port >= NPORTS are skipped and counted;
// otherwise they are routed to port D mod NPORTS.
module packet_router_n #(
  parameter int NPORTS = 3,
  parameter int DEPTH = 64,
  parameter int MAXLENGTH = 12
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [7:0]            i_data,
  input  logic                  i_end,
  output logic                  i_ready,
  output logic [NPORTS-1:0]     o_start,
  output logic [NPORTS-1:0]     o_end,
  output logic [8*NPORTS-1:0]   o_data,
  output logic [6*NPORTS-1:0]   o_length,
  output logic [NPORTS-1:0]     o_req,
  input  logic [NPORTS-1:0]     o_grant,
  output logic [7:0]            drop_cnt,
  output logic                  overflow
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, HDR, WAIT, SEND, SKIP} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ, pkt_cnt;
  logic w_valid, w_end;
  logic [7:0] w_data, hdr, rdata;
  logic [5:0] cnt, len;
  logic [1:0] dst, port;
  logic rv, rfirst, rlast;
  logic bad, skip_c, last_c, grant;
  logic hdr_rd, pay_rd, rd, req_set, drop_inc;
  assign len = hdr[7:2];
  assign dst = hdr[1:0];
`ifdef PKT_DROP_BAD_PORT_EN
  assign bad = 32'(dst) >= NPORTS;
  assign port = dst;
`else
  assign bad = 1'b0;
  assign port = 2'(32'(dst) % NPORTS);
`endif
  assign skip_c = len == 6'd0 || bad;
  assign last_c = cnt == len - 6'd1;
  assign grant = o_grant[port];
  assign i_ready = occ < (AW+1)'(DEPTH - MAXLENGTH);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = pkt_cnt != '0 ? HDR : IDLE;
      HDR: state_n = skip_c ? SKIP : WAIT;
      WAIT: state_n = !grant ? WAIT : last_c ? IDLE : SEND;
      SEND: state_n = last_c ? IDLE : SEND;
      SKIP: state_n = (len == 6'd0 || last_c) ? IDLE : SKIP;
      default: state_n = IDLE;
    endcase
  end
  // cnt indexes the payload word being read; the grant cycle reads word 0
  always_comb begin
    hdr_rd = state == IDLE && pkt_cnt != '0;
    pay_rd = (state == WAIT && grant) || state == SEND;
    rd = hdr_rd || pay_rd || (state == SKIP && len != 6'd0);
    req_set = state == HDR && !skip_c;
    drop_inc = state == SKIP && (len == 6'd0 || last_c) && drop_cnt != 8'hFF;
  end
  // input beats land in a staging register and reach the FIFO one cycle later;
  // payload words pass a read register and then the per-port output register
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      {w_valid, w_end, w_data, overflow} <= '0;
      {wr_ptr, rd_ptr, occ, pkt_cnt} <= '0;
      {hdr, rdata, cnt, rv, rfirst, rlast, drop_cnt} <= '0;
      {o_start, o_end, o_data, o_length, o_req} <= '0;
    end else begin
      w_valid <= i_valid && i_ready;
      w_data <= i_data;
      w_end <= i_end;
      overflow <= overflow || (i_valid && !i_ready);
      if (w_valid) mem[wr_ptr] <= w_data;
      wr_ptr <= wr_ptr + AW'(w_valid);
      rd_ptr <= rd_ptr + AW'(rd);
      occ <= occ + (AW+1)'(w_valid) - (AW+1)'(rd);
      pkt_cnt <= pkt_cnt + (AW+1)'(w_valid && w_end) - (AW+1)'(hdr_rd);
      if (hdr_rd) hdr <= mem[rd_ptr];
      rdata <= mem[rd_ptr];
      rv <= pay_rd;
      rfirst <= state == WAIT;
      rlast <= last_c;
      cnt <= state == HDR ? 6'd0 : cnt + 6'(rd);
      drop_cnt <= drop_cnt + 8'(drop_inc);
      for (int p = 0; p < NPORTS; p++) begin
        o_start[p] <= rv && rfirst && port == 2'(p);
        o_end[p] <= rv && rlast && port == 2'(p);
        o_data[8*p+:8] <= (rv && port == 2'(p)) ? rdata : 8'd0;
        o_req[p] <= (req_set && port == 2'(p)) || (o_req[p] && !pay_rd);
        o_length[6*p+:6] <= (req_set && port == 2'(p)) ? len : (|o_end) ? 6'd0 : o_length[6*p+:6];
      end
    end
endmodule
